alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//  Registered output stage placed directly after the 16-bit ALU datapath built from the
//  AND16/OR16/ADD16 bitwise units. Accepts one ALU result per valid/ready handshake,
//  computes the zero and negative status flags, and tags each result with a wrapping
//  sequence number. Presents the result to the register-write/branch logic through a
//  2-entry skid buffer, so downstream back-pressure never creates a combinational path
//  to the ALU.
// PARAMETERS
//  WIDTH  16  data width of the ALU result
//  SEQ_W  4   width of the sequence tag; wraps modulo 2**SEQ_W
// PORTS
//  CLK        in   1      single clock; all state updates on rising edge
//  RST_N      in   1      asynchronous, active-low reset
//  FLUSH      in   1      synchronous clear of buffered results and sequence counter
//  IN_VALID   in   1      ALU result on IN_DATA is valid
//  IN_READY   out  1      stage can accept a result this cycle (registered)
//  IN_DATA    in   WIDTH  ALU result
//  OUT_VALID  out  1      OUT_* fields hold a valid result
//  OUT_READY  in   1      downstream consumes the result this cycle
//  OUT_DATA   out  WIDTH  buffered result
//  OUT_ZR     out  1      1 iff OUT_DATA == 0
//  OUT_NG     out  1      OUT_DATA[WIDTH-1]
//  OUT_SEQ    out  SEQ_W  sequence tag of the presented result
// BEHAVIOUR
//  - Reset (RST_N low, async): OUT_VALID=0, OUT_DATA=0, OUT_ZR=1, OUT_NG=0, OUT_SEQ=0,
//    both entries empty, sequence counter=0, IN_READY=0 while RST_N is low.
//    IN_READY=1 from the first rising edge after release.
//  - Input transfer = IN_VALID & IN_READY at a rising edge. Output transfer =
//    OUT_VALID & OUT_READY at a rising edge.
//  - Flags are computed from IN_DATA at acceptance and stored with the entry. They are
//    never recomputed from OUT_DATA.
//  - Entries: MAIN (drives OUT_*) and SKID. IN_READY = !SKID_valid, registered.
//  - States and transitions (in = input transfer, out = output transfer):
//    EMPTY: in -> ONE (MAIN loaded; OUT_VALID=1 next cycle; latency 1).
//    ONE:   in&out -> ONE (MAIN replaced). in&!out -> TWO (new result goes to SKID).
//           !in&out -> EMPTY. Otherwise hold.
//    TWO:   IN_READY=0. out -> ONE (SKID moves to MAIN same edge). Otherwise hold.
//  - Results leave in acceptance order. No result is duplicated or dropped except by
//    FLUSH or reset.
//  - OUT_* fields are stable while OUT_VALID=1 & OUT_READY=0.
//  - Sequence counter increments by 1 on each input transfer. The accepted entry
//    captures the pre-increment value. Wraps 2**SEQ_W-1 -> 0 silently.
//  - FLUSH (sync, priority over everything else): next cycle is EMPTY, counter=0,
//    OUT_VALID=0, IN_READY=1.
//    An input handshake coinciding with FLUSH is discarded and does not increment the
//    counter; upstream treats it as dropped.
//    OUT_DATA/flags/SEQ after FLUSH are don't-care while OUT_VALID=0.
//  - Reset asserted mid-operation: immediate return to reset values; buffered results
//    are lost.
//  - Throughput: 1 result/cycle while OUT_READY=1. Max 2 results buffered.
// TESTING
//  1 Reset: hold RST_N=0 -> OUT_VALID=0, OUT_ZR=1, OUT_SEQ=0, IN_READY=0; release ->
//    IN_READY=1 next edge.
//  2 Stream 0x0000,0x8001,0x7FFF with OUT_READY=1 -> each appears 1 cycle later;
//    ZR/NG = 1/0, 0/1, 0/0; SEQ = 0,1,2.
//  3 OUT_READY=0, send 0x1234 then 0x00FF -> IN_READY=0 after the second edge;
//    OUT_DATA holds 0x1234. Raise OUT_READY -> 0x1234 then 0x00FF, with no gap and
//    no loss.
//  4 Send 17 results with SEQ_W=4 -> OUT_SEQ runs 0..15 then 0.
//  5 Two entries buffered, pulse FLUSH while IN_VALID=1 (0xAAAA) -> next cycle
//    OUT_VALID=0, IN_READY=1; next accepted result has SEQ=0; 0xAAAA never appears.
//  6 Drop RST_N asynchronously with OUT_VALID=1 mid-cycle -> OUT_VALID falls
//    immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered output stage for the 16-bit ALU: adds zero/negative flags and a wrapping
// sequence tag, and decouples downstream back-pressure through a 2-entry skid buffer.
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int SEQ_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zr,
    output logic             out_ng,
    output logic [SEQ_W-1:0] out_seq
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zr;
        logic             ng;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam entry_t RESET_ENTRY = '{data: '0, zr: 1'b1, ng: 1'b0, seq: '0};

    state_t           state;
    entry_t           main_entry;
    entry_t           skid_entry;
    entry_t           new_entry;
    logic [SEQ_W-1:0] seq_cnt;
    logic             in_xfer;
    logic             out_xfer;

    // Flags are captured once at acceptance and travel with the entry.
    always_comb begin
        new_entry      = RESET_ENTRY;
        new_entry.data = in_data;
        new_entry.zr   = (in_data == '0);
        new_entry.ng   = in_data[WIDTH-1];
        new_entry.seq  = seq_cnt;
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // NOTE: every register here is updated with <= so all entries move on the same edge
    // without ordering hazards between the MAIN and SKID transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            main_entry <= RESET_ENTRY;
            skid_entry <= RESET_ENTRY;
            seq_cnt    <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            seq_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            if (in_xfer)
                seq_cnt <= seq_cnt + 1'b1;
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_entry <= new_entry;
                        out_valid  <= 1'b1;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_entry <= new_entry;
                    end else if (in_xfer) begin
                        skid_entry <= new_entry;
                        in_ready   <= 1'b0;
                        state      <= TWO;
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_xfer) begin
                        main_entry <= skid_entry;
                        state      <= ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

    assign out_data = main_entry.data;
    assign out_zr   = main_entry.zr;
    assign out_ng   = main_entry.ng;
    assign out_seq  = main_entry.seq;

endmodule
